psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter DW, default 8: output activation width, signed.
REQ-002 SHALL have parameter OW, default 19: per-lane partial-sum width, signed.
REQ-003 SHALL have parameter COLUMN, default 7: lanes per partial-sum vector.
REQ-004 SHALL have parameter AW, default OW+4: accumulator width, signed.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: begin one tile; sampled only in IDLE.
REQ-008 SHALL have port cfg_passes, input, 4: number of vectors to accumulate; 0 is treated as 1.
REQ-009 SHALL have port cfg_shift, input, 5: arithmetic right-shift amount for requantization.
REQ-010 SHALL have port cfg_relu, input, 1: clamp negative results to 0.
REQ-011 SHALL have port ci_valid, input, 1: partial-sum vector valid.
REQ-012 SHALL have port ci, input, COLUMN*OW: lane i at bits [i*OW +: OW], signed.
REQ-013 SHALL have port ci_ready, output, 1: vector accept.
REQ-014 SHALL have port out_valid, output, 1: output byte valid.
REQ-015 SHALL have port out_data, output, DW: requantized lane value, signed.
REQ-016 SHALL have port out_col, output, $clog2(COLUMN): lane index of out_data.
REQ-017 SHALL have port out_last, output, 1: marks lane COLUMN-1.
REQ-018 SHALL have port out_ready, input, 1: downstream accept.
REQ-019 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 SHALL implement the states IDLE, ACC, QUANT and DRAIN.
REQ-021 IDLE: on start=1, SHALL latch cfg_passes, cfg_shift and cfg_relu, zero all COLUMN accumulators and the pass counter, and go to ACC.
REQ-022 ACC: ci_ready SHALL be 1; a vector is accepted when ci_valid&&ci_ready; on accept, acc[i] += sign-extended lane i, and the pass counter increments.
REQ-023 ACC: the cycle that accepts vector number cfg_passes SHALL transition to QUANT, and ci_ready SHALL be 0 from the next cycle.
REQ-024 QUANT lasts exactly one cycle: q[i] = sat_DW((acc[i] + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift); the rounding add and shift SHALL be done at AW+1 bits.
REQ-025 Saturation SHALL clamp to the range [-2^(DW-1), 2^(DW-1)-1]; when cfg_relu=1, negative results SHALL become 0 after saturation.
REQ-026 QUANT SHALL store q[0..COLUMN-1] in an output buffer, set the column counter to 0, and go to DRAIN.
REQ-027 DRAIN: out_valid=1, out_data=q[col], out_col=col, and out_last=(col==COLUMN-1).
REQ-028 DRAIN: while out_valid=1 and out_ready=0, out_data, out_col and out_last SHALL hold stable.
REQ-029 DRAIN: on out_ready, col SHALL increment; accepting the out_last byte SHALL return to IDLE, with out_valid=0 in the next cycle.
REQ-030 Latency: the last ci accepted at edge t SHALL produce out_valid=1 after edge t+2; with out_ready held at 1, the tile drains in COLUMN cycles.
REQ-031 start SHALL be ignored outside IDLE; the latched cfg values SHALL NOT change mid-tile.
REQ-032 ci_valid while not in ACC SHALL be ignored, with no accumulation.
REQ-033 A start and a ci_valid arriving in the same IDLE cycle: only the start SHALL take effect.
REQ-034 AW=OW+4 SHALL hold 15 passes without overflow; there is no wrap-around handling.
REQ-035 out_valid SHALL NOT depend combinationally on out_ready, and ci_ready SHALL NOT depend combinationally on ci_valid.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE with accumulators, counters and the buffer cleared, and ci_ready=0, out_valid=0, out_data=0, out_col=0, out_last=0, busy=0.
REQ-037 Reset mid-tile (ACC or DRAIN) SHALL discard all partial results; after rst_n rises, no output SHALL appear until a new start.

Verification
REQ-038 Set passes=3, shift=0, relu=0; drive 3 vectors with every lane =10 -> 7 bytes of 30, out_col 0..6, out_last on col 6, first out_valid 2 cycles after the 3rd accept.
REQ-039 Set shift=2; drive one lane sum of 6 and one of -6 -> output bytes 2 and -1 (round half up: (6+2)>>>2=2, (-6+2)>>>2=-1).
REQ-040 Saturation: a lane sum of +1000 with shift=0 -> 127; a sum of -1000 -> -128; with relu=1, the -1000 lane -> 0.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles at col 3 -> out_data and out_col stable; the remaining bytes drain in order with no loss or duplication.
REQ-042 Set passes=0 -> exactly 1 vector is accepted; start pulsed during DRAIN is ignored; ci_valid in IDLE causes no change to the next tile result.
REQ-043 Assert rst_n=0 in ACC after 2 of 4 vectors; then start a new tile with passes=1 and lanes =5 -> outputs are 5, with no residue from the aborted tile.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: accumulates a configurable number of partial-sum vectors per
// tile, requantizes every lane (round half up, arithmetic shift, saturate,
// optional ReLU) and drains the lane bytes one at a time over a
// valid/ready stream.
module psum_drain #(
  parameter int DW     = 8,
  parameter int OW     = 19,
  parameter int COLUMN = 7,
  parameter int AW     = OW + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              cfg_passes,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  input  logic                    ci_valid,
  input  logic [COLUMN*OW-1:0]    ci,
  output logic                    ci_ready,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(COLUMN)-1:0] out_col,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int CW = $clog2(COLUMN);

  // Saturation bounds expressed at the rounding width (AW+1 bits).
  localparam logic signed [AW:0] QMAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] QMIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_QUANT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [3:0]            passes_r;
  logic [4:0]            shift_r;
  logic                  relu_r;
  logic [3:0]            cnt_r;
  logic signed [AW-1:0]  acc_r [COLUMN];
  logic [DW-1:0]         obuf_r [COLUMN];
  logic [CW-1:0]         col_r;
  logic                  out_valid_r;
  logic [DW-1:0]         out_data_r;
  logic [CW-1:0]         out_col_r;
  logic                  out_last_r;

  logic [4:0]            eff_passes_s;
  logic                  accept_s;
  logic                  last_pass_s;
  logic                  load_s;
  logic                  done_s;

  // Requantize one accumulator: round half up, arithmetic shift, saturate, ReLU.
  function automatic logic [DW-1:0] requant(input logic signed [AW-1:0] a,
                                            input logic [4:0] sh,
                                            input logic relu);
    logic signed [AW:0] ext;
    logic signed [AW:0] rnd;
    logic signed [AW:0] res;
    logic [DW-1:0]      q;
    ext = {a[AW-1], a};
    rnd = '0;
    if (sh != 5'd0) begin
      rnd = {{AW{1'b0}}, 1'b1} << (sh - 5'd1);
    end else begin
      rnd = '0;
    end
    res = (ext + rnd) >>> sh;
    if (res > QMAX) begin
      q = {1'b0, {(DW-1){1'b1}}};
    end else if (res < QMIN) begin
      q = {1'b1, {(DW-1){1'b0}}};
    end else begin
      q = res[DW-1:0];
    end
    if (relu && q[DW-1]) begin
      q = '0;
    end else begin
      q = q;
    end
    return q;
  endfunction

  assign ci_ready  = (state_r == S_ACC);
  assign busy      = (state_r != S_IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_col   = out_col_r;
  assign out_last  = out_last_r;

  // Handshake decodes and next-state selection.
  always_comb begin
    eff_passes_s = (passes_r == 4'd0) ? 5'd1 : {1'b0, passes_r};
    accept_s     = ci_valid && (state_r == S_ACC);
    last_pass_s  = accept_s && (({1'b0, cnt_r} + 5'd1) == eff_passes_s);
    done_s       = (state_r == S_DRAIN) && out_valid_r && out_ready && out_last_r;
    load_s       = (state_r == S_DRAIN) && (!out_valid_r || (out_ready && !out_last_r));
    state_s      = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_ACC;
        else       state_s = S_IDLE;
      end
      S_ACC: begin
        if (last_pass_s) state_s = S_QUANT;
        else             state_s = S_ACC;
      end
      S_QUANT: state_s = S_DRAIN;
      S_DRAIN: begin
        if (done_s) state_s = S_IDLE;
        else        state_s = S_DRAIN;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Config latch, accumulation, requantization and drain output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      passes_r    <= 4'd0;
      shift_r     <= 5'd0;
      relu_r      <= 1'b0;
      cnt_r       <= 4'd0;
      col_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_col_r   <= '0;
      out_last_r  <= 1'b0;
      for (int i = 0; i < COLUMN; i++) begin
        acc_r[i]  <= '0;
        obuf_r[i] <= '0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            passes_r <= cfg_passes;
            shift_r  <= cfg_shift;
            relu_r   <= cfg_relu;
            cnt_r    <= 4'd0;
            for (int i = 0; i < COLUMN; i++) acc_r[i] <= '0;
          end
        end
        S_ACC: begin
          if (accept_s) begin
            cnt_r <= cnt_r + 4'd1;
            for (int i = 0; i < COLUMN; i++) begin
              acc_r[i] <= acc_r[i] + {{(AW-OW){ci[i*OW+OW-1]}}, ci[i*OW +: OW]};
            end
          end
        end
        S_QUANT: begin
          for (int i = 0; i < COLUMN; i++) obuf_r[i] <= requant(acc_r[i], shift_r, relu_r);
          col_r <= '0;
        end
        S_DRAIN: begin
          if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= obuf_r[col_r];
            out_col_r   <= col_r;
            out_last_r  <= (col_r == CW'(COLUMN - 1));
            col_r       <= col_r + CW'(1);
          end else if (done_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_col_r   <= '0;
            out_last_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with a tile-level reference model and a
// per-cycle compare process sampling on the falling clock edge.
module tb_psum_drain;
  localparam int DW     = 8;
  localparam int OW     = 19;
  localparam int COLUMN = 7;
  localparam int AW     = OW + 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [3:0]             cfg_passes = 4'd0;
  logic [4:0]             cfg_shift = 5'd0;
  logic                   cfg_relu = 1'b0;
  logic                   ci_valid = 1'b0;
  logic [COLUMN*OW-1:0]   ci = '0;
  logic                   ci_ready;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [$clog2(COLUMN)-1:0] out_col;
  logic                   out_last;
  logic                   out_ready = 1'b1;
  logic                   busy;

  psum_drain #(.DW(DW), .OW(OW), .COLUMN(COLUMN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_passes(cfg_passes),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .ci_valid(ci_valid), .ci(ci),
    .ci_ready(ci_ready), .out_valid(out_valid), .out_data(out_data),
    .out_col(out_col), .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int got[$];

  // Reference model: mode 0 idle, 1 accumulating, 2 waiting for output, 3 draining.
  int     m_mode = 0;
  int     m_wait = 0;
  int     m_col = 0;
  int     m_cnt = 0;
  int     m_passes = 0;
  int     m_shift = 0;
  bit     m_relu = 1'b0;
  bit     m_valid;
  longint m_acc[COLUMN];
  int     m_exp[COLUMN];
  int     vec[COLUMN];
  int     lit[COLUMN];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mq(input longint a, input int sh, input bit relu);
    longint v;
    v = a;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (relu && v < 0) v = 0;
    return int'(v);
  endfunction

  // Compare DUT outputs with the model, then advance the model to the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_col", out_col, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ci_ready", ci_ready, 0);
      m_mode = 0;
    end else begin
      m_valid = (m_mode == 3);
      chk("busy", busy, m_mode != 0);
      chk("ci_ready", ci_ready, m_mode == 1);
      chk("out_valid", out_valid, m_valid);
      if (m_valid && out_valid) begin
        chk("out_data", $signed(out_data), m_exp[m_col]);
        chk("out_col", out_col, m_col);
        chk("out_last", out_last, m_col == COLUMN - 1);
        if (out_ready) got.push_back(int'($signed(out_data)));
      end
      case (m_mode)
        0: if (start) begin
          m_passes = (cfg_passes == 4'd0) ? 1 : int'(cfg_passes);
          m_shift = int'(cfg_shift);
          m_relu = cfg_relu;
          m_cnt = 0;
          for (int i = 0; i < COLUMN; i++) m_acc[i] = 0;
          m_mode = 1;
        end
        1: if (ci_valid) begin
          for (int i = 0; i < COLUMN; i++) m_acc[i] += $signed(ci[i*OW +: OW]);
          m_cnt++;
          if (m_cnt == m_passes) begin
            for (int i = 0; i < COLUMN; i++) m_exp[i] = mq(m_acc[i], m_shift, m_relu);
            m_mode = 2;
            m_wait = 2;
          end
        end
        2: begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode = 3;
            m_col = 0;
          end
        end
        3: if (out_ready) begin
          if (m_col == COLUMN - 1) m_mode = 0;
          else m_col++;
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic set_lanes(input int v[COLUMN]);
    for (int i = 0; i < COLUMN; i++) ci[i*OW +: OW] = OW'(v[i]);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < COLUMN; i++) ci[i*OW +: OW] = OW'(v);
  endtask

  // Start a tile, then scramble the cfg inputs to show they were latched.
  task automatic do_start(input int p, input int s, input bit r);
    start = 1'b1;
    cfg_passes = 4'(p);
    cfg_shift = 5'(s);
    cfg_relu = r;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_passes = 4'hF;
    cfg_shift = 5'd7;
    cfg_relu = ~r;
  endtask

  task automatic send_cur();
    int n;
    n = 0;
    ci_valid = 1'b1;
    while (!ci_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ci_accept", ci_ready, 1);
    @(posedge clk); #1;
    ci_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit stall);
    int cyc;
    bit stalled;
    logic [DW-1:0] hd;
    logic [2:0] hc;
    cyc = 0;
    stalled = 1'b0;
    while (got.size() < n && cyc < 300) begin
      if (stall && !stalled && out_valid && out_col == 3'd3) begin
        out_ready = 1'b0;
        hd = out_data;
        hc = out_col;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_data", out_data, hd);
          chk("stall_col", out_col, hc);
          chk("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        stalled = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("drain_count", got.size(), n);
    if (stall) chk("stall_seen", stalled, 1);
    @(posedge clk); #1;
    chk("idle_after_drain", busy, 0);
  endtask

  task automatic check_lit(input string name);
    for (int i = 0; i < COLUMN; i++) begin
      if (i < got.size()) chk(name, got[i], lit[i]);
      else chk(name, -999, lit[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Three passes of 10 per lane, no shift; pin the two-cycle latency.
    got.delete();
    do_start(3, 0, 1'b0);
    set_all(10);
    send_cur(); send_cur(); send_cur();
    chk("lat_t0", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_t1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_t2", out_valid, 1);
    chk("lat_t2_col", out_col, 0);
    drain(7, 1'b0);
    lit = '{30, 30, 30, 30, 30, 30, 30};
    check_lit("tile_sum30");

    // Shift 2 with round half up.
    got.delete();
    do_start(2, 2, 1'b0);
    vec = '{4, -4, 1, 2, 0, 100, -100}; set_lanes(vec); send_cur();
    vec = '{2, -2, 1, 3, 1, 1, -1};     set_lanes(vec); send_cur();
    drain(7, 1'b0);
    lit = '{2, -1, 1, 1, 0, 25, -25};
    check_lit("round_shift2");

    // Saturation, then the same sums with ReLU.
    got.delete();
    do_start(1, 0, 1'b0);
    vec = '{1000, -1000, 127, 128, -128, -129, 0}; set_lanes(vec); send_cur();
    drain(7, 1'b0);
    lit = '{127, -128, 127, 127, -128, -128, 0};
    check_lit("saturate");
    got.delete();
    do_start(1, 0, 1'b1);
    set_lanes(vec); send_cur();
    drain(7, 1'b0);
    lit = '{127, 0, 127, 127, 0, 0, 0};
    check_lit("saturate_relu");

    // Backpressure at column 3 for five cycles.
    got.delete();
    do_start(1, 0, 1'b0);
    vec = '{1, 2, 3, 4, 5, 6, 7}; set_lanes(vec); send_cur();
    drain(7, 1'b1);
    lit = '{1, 2, 3, 4, 5, 6, 7};
    check_lit("backpressure");

    // passes=0 accepts one vector; extra ci_valid and a start pulse are ignored.
    got.delete();
    do_start(0, 0, 1'b0);
    set_all(9);
    send_cur();
    set_all(100);
    ci_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain(7, 1'b0);
    ci_valid = 1'b0;
    lit = '{9, 9, 9, 9, 9, 9, 9};
    check_lit("passes0");

    // ci_valid in IDLE, and together with start, contributes nothing.
    got.delete();
    set_all(50);
    ci_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_start(1, 0, 1'b0);
    set_all(4);
    send_cur();
    drain(7, 1'b0);
    lit = '{4, 4, 4, 4, 4, 4, 4};
    check_lit("idle_ci_ignored");

    // Reset in ACC after 2 of 4 vectors; the next tile shows no residue.
    got.delete();
    do_start(4, 0, 1'b0);
    set_all(7);
    send_cur(); send_cur();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_quiet", got.size(), 0);
    do_start(1, 0, 1'b0);
    set_all(5);
    send_cur();
    drain(7, 1'b0);
    lit = '{5, 5, 5, 5, 5, 5, 5};
    check_lit("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
